// File: rtl/arquitetura_joystick_pio_edge.sv
// Avalon-MM PIO for joystick/button lines: per-bit synchroniser, debouncer,
// edge capture with per-bit edge mode, interrupt mask and registered readback.
module arquitetura_joystick_pio_edge #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  sync_out;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]       cnt_n;
  logic [DATA_WIDTH-1:0]                  stable_q;
  logic [DATA_WIDTH-1:0]                  stable_n;
  logic [DATA_WIDTH-1:0]                  stable_d_q;
  logic [DATA_WIDTH-1:0]                  irq_mask_q;
  logic [DATA_WIDTH-1:0]                  edge_capture_q;
  logic [DATA_WIDTH-1:0]                  edge_mode_q;
  logic [DATA_WIDTH-1:0]                  edge_ev;
  logic [DATA_WIDTH-1:0]                  clr_mask;
  logic [DATA_WIDTH-1:0]                  rd_mux;
  logic                                   wr;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign wr       = chipselect & ~write_n;

  // Metastability chain; nothing downstream sees in_port directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  // Per-bit debounce: a level is accepted on the DEBOUNCE_CNT-th mismatching cycle.
  always_comb begin
    stable_n = stable_q;
    cnt_n    = '0;
    for (int b = 0; b < int'(DATA_WIDTH); b++) begin
      if (sync_out[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          stable_n[b] = sync_out[b];
        end else begin
          cnt_n[b] = cnt_q[b] + CNT_ONE;
        end
      end
    end
  end

  // Edges come only from the stable vector, so edgemode writes never fake one.
  always_comb begin
    edge_ev  = (stable_q & ~stable_d_q) | (~stable_q & stable_d_q & edge_mode_q);
    clr_mask = (wr && address == ADDR_EDGE) ? writedata : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = stable_q;
      ADDR_MASK: rd_mux = irq_mask_q;
      ADDR_EDGE: rd_mux = edge_capture_q;
      ADDR_MODE: rd_mux = edge_mode_q;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      stable_q       <= '0;
      stable_d_q     <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      edge_mode_q    <= '0;
      readdata       <= '0;
    end else begin
      cnt_q          <= cnt_n;
      stable_q       <= stable_n;
      stable_d_q     <= stable_q;
      // A coincident edge overrides the write-1-to-clear.
      edge_capture_q <= (edge_capture_q & ~clr_mask) | edge_ev;
      if (wr && address == ADDR_MASK) irq_mask_q  <= writedata;
      if (wr && address == ADDR_MODE) edge_mode_q <= writedata;
      readdata       <= rd_mux;
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_arquitetura_joystick_pio_edge.sv
// Directed bench for arquitetura_joystick_pio_edge with DATA_WIDTH=8,
// SYNC_STAGES=2, DEBOUNCE_CNT=4 (input-to-stable latency of 6 clocks).
module tb_arquitetura_joystick_pio_edge;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic [DW-1:0] in_port;
  logic          irq;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] rv;

  arquitetura_joystick_pio_edge #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2),
    .DEBOUNCE_CNT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d, input logic cs = 1'b1);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [DW-1:0] d);
    address = a;
    step();
    d       = readdata;
    address = 2'd0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    step(3);
    reset = 1'b0;

    // Reset state
    check_eq("rst_readdata", 32'(readdata), 32'h00);
    check_eq("rst_irq", 32'(irq), 32'h0);
    bus_read(2'd1, rv); check_eq("rst_mask", 32'(rv), 32'h00);
    bus_read(2'd2, rv); check_eq("rst_edge", 32'(rv), 32'h00);
    bus_read(2'd3, rv); check_eq("rst_mode", 32'(rv), 32'h00);

    // Rising bit0: stable after 6 clocks, edgecapture one clock later
    bus_write(2'd1, 8'hFF);
    in_port = 8'h01;
    step(6);
    check_eq("lat_data_c6", 32'(readdata), 32'h00);
    check_eq("lat_irq_c6", 32'(irq), 32'h0);
    step();
    check_eq("lat_data_c7", 32'(readdata), 32'h01);
    check_eq("lat_irq_c7", 32'(irq), 32'h1);
    bus_read(2'd2, rv); check_eq("lat_edge", 32'(rv), 32'h01);
    bus_write(2'd2, 8'hFF);
    check_eq("clr_irq", 32'(irq), 32'h0);
    bus_read(2'd2, rv); check_eq("clr_edge", 32'(rv), 32'h00);

    // 3-cycle glitch on bit1 is rejected
    in_port = 8'h03;
    step(3);
    in_port = 8'h01;
    step(10);
    bus_read(2'd0, rv); check_eq("glitch_data", 32'(rv), 32'h01);
    bus_read(2'd2, rv); check_eq("glitch_edge", 32'(rv), 32'h00);
    check_eq("glitch_irq", 32'(irq), 32'h0);

    // Falling bit0 with rising-only mode: no capture
    in_port = 8'h00;
    step(8);
    bus_read(2'd0, rv); check_eq("fall_data", 32'(rv), 32'h00);
    bus_read(2'd2, rv); check_eq("fall_rise_only", 32'(rv), 32'h00);

    // irqmask=0x01, rise on bit0 raises irq, clear drops it
    bus_write(2'd1, 8'h01);
    in_port = 8'h01;
    step(8);
    check_eq("mask_irq_set", 32'(irq), 32'h1);
    bus_write(2'd2, 8'h01);
    check_eq("mask_irq_clr", 32'(irq), 32'h0);
    bus_read(2'd2, rv); check_eq("mask_edge_clr", 32'(rv), 32'h00);

    // Clear coinciding with a new edge: set wins
    in_port = 8'h00;
    step(8);
    in_port = 8'h01;
    step(6);
    bus_write(2'd2, 8'h01);
    check_eq("coinc_irq", 32'(irq), 32'h1);
    bus_read(2'd2, rv); check_eq("coinc_edge", 32'(rv), 32'h01);
    bus_write(2'd2, 8'hFF);

    // Any-edge mode on bit2
    bus_write(2'd3, 8'h04);
    bus_read(2'd3, rv); check_eq("mode_rd", 32'(rv), 32'h04);
    in_port = 8'h05;
    step(8);
    bus_read(2'd2, rv); check_eq("any_rise", 32'(rv), 32'h04);
    bus_write(2'd2, 8'h04);
    in_port = 8'h01;
    step(8);
    bus_read(2'd2, rv); check_eq("any_fall", 32'(rv), 32'h04);
    bus_write(2'd2, 8'h04);
    bus_write(2'd3, 8'h00);
    bus_read(2'd2, rv); check_eq("mode_chg_no_edge", 32'(rv), 32'h00);
    in_port = 8'h05;
    step(8);
    bus_read(2'd2, rv); check_eq("rise_mode0", 32'(rv), 32'h04);
    bus_write(2'd2, 8'h04);
    in_port = 8'h01;
    step(8);
    bus_read(2'd2, rv); check_eq("fall_mode0", 32'(rv), 32'h00);

    // Write to data register and writes without chipselect are ignored
    bus_write(2'd0, 8'hFF);
    bus_read(2'd0, rv); check_eq("data_ro", 32'(rv), 32'h01);
    bus_write(2'd1, 8'hAA, 1'b0);
    bus_write(2'd3, 8'h55, 1'b0);
    bus_read(2'd1, rv); check_eq("nocs_mask", 32'(rv), 32'h01);
    bus_read(2'd3, rv); check_eq("nocs_mode", 32'(rv), 32'h00);

    // Reset in the middle of a bit3 debounce, level re-qualified afterwards
    bus_write(2'd1, 8'hFF);
    in_port = 8'h00;
    step(8);
    bus_write(2'd2, 8'hFF);
    in_port = 8'h08;
    step(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mrst_readdata", 32'(readdata), 32'h00);
    check_eq("mrst_irq", 32'(irq), 32'h0);
    step(6);
    check_eq("mrst_data_c6", 32'(readdata), 32'h00);
    check_eq("mrst_irq_c6", 32'(irq), 32'h0);
    step();
    check_eq("mrst_data_c7", 32'(readdata), 32'h08);
    check_eq("mrst_irq_c7", 32'(irq), 32'h0);
    bus_read(2'd1, rv); check_eq("mrst_mask", 32'(rv), 32'h00);
    bus_read(2'd3, rv); check_eq("mrst_mode", 32'(rv), 32'h00);
    bus_read(2'd2, rv); check_eq("mrst_edge", 32'(rv), 32'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arquitetura_joystick_pio_edge.md
ARQUITETURA_JOYSTICK_PIO_EDGE -- requirements
Module: arquitetura_joystick_pio_edge

Interface
REQ-001 The block SHALL be parameterised as follows: DATA_WIDTH, default 32, width of the input port and of all data registers.
REQ-002 The block SHALL be parameterised as follows: SYNC_STAGES, default 2, minimum 2, number of metastability flops per input bit.
REQ-003 The block SHALL be parameterised as follows: DEBOUNCE_CNT, default 1000, minimum 1, number of consecutive stable cycles required to accept a new level.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports: clk  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL provide: address  input  2  Avalon-MM register select.
REQ-007 The block SHALL provide: chipselect  input  1  qualifies writes.
REQ-008 The block SHALL provide: write_n  input  1  active-low write strobe.
REQ-009 The block SHALL provide: writedata  input  DATA_WIDTH  write data.
REQ-010 The block SHALL provide: readdata  output  DATA_WIDTH  registered read data.
REQ-011 The block SHALL provide: in_port  input  DATA_WIDTH  asynchronous joystick/button lines.
REQ-012 The block SHALL provide: irq  output  1  level interrupt, active-high.

Function
REQ-013 The register map SHALL be:
- 0: debounced data, read-only; writes ignored.
- 1: irqmask, R/W.
- 2: edgecapture, read; write-1-to-clear.
- 3: edgemode, R/W; per bit 0 = rising edge only, 1 = any edge.
REQ-014 Each in_port bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-015 Each bit SHALL have an independent debounce counter of width clog2(DEBOUNCE_CNT+1), operating as follows:
- synchronised bit equals the stable bit: counter reset to 0.
- otherwise: counter increments.
- when the counter would reach DEBOUNCE_CNT: stable bit takes the synchronised value and the counter returns to 0.
REQ-016 A glitch shorter than DEBOUNCE_CNT cycles at the synchroniser output SHALL NOT change the stable bit and SHALL NOT set edgecapture.
REQ-017 Latency from an in_port change, held stable, to the stable bit changing SHALL be exactly SYNC_STAGES + DEBOUNCE_CNT cycles.
REQ-018 A registered copy of the stable vector SHALL be kept. An edge on a bit is a stable rise, or a stable fall when edgemode for that bit is 1.
REQ-019 An edge SHALL set the corresponding edgecapture bit on the clock after the stable bit changes. The bit then stays set until cleared.
REQ-020 A write is chipselect=1 and write_n=0. A write to address 2 SHALL clear every edgecapture bit where writedata is 1.
REQ-021 If an edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-022 Writes to addresses 1 and 3 SHALL update the register on the next clock edge. An edgemode change SHALL NOT itself generate an edge.
REQ-023 irq SHALL be the OR-reduction of (edgecapture AND irqmask), derived from registers only. irq SHALL respond within the cycle after edgecapture or irqmask changes.
REQ-024 readdata SHALL be registered every cycle from the address-selected register, independent of chipselect, giving read latency 1.
REQ-025 Unused upper bits SHALL NOT exist: all registers are full DATA_WIDTH.

Reset
REQ-026 While reset=1 at a clock edge, the following SHALL be cleared to 0: sync flops, stable vector, its delayed copy, debounce counters, irqmask, edgecapture, edgemode and readdata.
REQ-027 Because the delayed copy also resets to 0, no edge SHALL be detected in the first cycle after reset.
REQ-028 Reset asserted mid-debounce SHALL abandon the count. A level still present after reset SHALL be re-qualified over a full SYNC_STAGES + DEBOUNCE_CNT cycles.
REQ-029 A rising level so qualified SHALL set edgecapture normally.

Verification
Bench parameters: DATA_WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CNT=4.
REQ-030 Scenario: in_port 0x00 -> 0x01 at cycle 0, held -> stable bit0=1 at cycle 6, edgecapture=0x01 at cycle 7, address 0 read gives readdata=0x01 one cycle after address is presented.
REQ-031 Scenario: bit1 pulses high for 3 cycles at the sync output -> data stays 0x00, edgecapture stays 0x00.
REQ-032 Scenario: irqmask=0x01, bit0 rises -> irq=1; write 0x01 to address 2 -> edgecapture=0x00, irq=0 next cycle; repeat with a new edge coinciding with the clear -> bit stays 1.
REQ-033 Scenario: edgemode=0x04, bit2 goes 1 then 0 -> edgecapture bit2 set on each transition; edgemode=0x00 -> falling transition leaves edgecapture unchanged.
REQ-034 Scenario: reset asserted at cycle 3 of a bit3 debounce, in_port held 0x08 -> all registers 0, no irq, data=0x08 six cycles after reset deasserts, edgecapture=0x08 one cycle later.
REQ-035 Scenario: write 0xFF to address 0 -> data register unchanged; writes with chipselect=0 to addresses 1/3 -> irqmask and edgemode unchanged.
